// File: rtl/afe_calib_ctrl.sv
// Calibration and sequencing controller for the optical AFE: per-channel DC-code binary search,
// PGA gain ramp to just below clipping, then time-multiplexed LED slots with one ADC capture each.
module afe_calib_ctrl #(
   parameter int NCH     = 2,
   parameter int ADC_W   = 8,
   parameter int DC_W    = 7,
   parameter int GAIN_W  = 4,
   parameter int WIN     = 1000,
   parameter int SETTLE  = 4,
   parameter int SLOT    = 10,
   parameter int TGT_LO  = 120,
   parameter int TGT_HI  = 135,
   parameter int CLIP_LO = 10,
   parameter int CLIP_HI = 245,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic [ADC_W-1:0]       ADC,
   input  logic                   find_setting,
   output logic [NCH-1:0]         led_en,
   output logic [DC_W-1:0]        dc_comp,
   output logic [GAIN_W-1:0]      pga_gain,
   output logic                   clk_filter,
   output logic                   busy,
   output logic                   done,
   output logic [NCH-1:0]         cal_err,
   output logic [NCH*ADC_W-1:0]   ch_value,
   output logic                   value_valid,
   output logic [CHW-1:0]         value_ch
);

   localparam int CNT_MAX = (WIN > SETTLE) ? ((WIN > SLOT) ? WIN : SLOT) : ((SETTLE > SLOT) ? SETTLE : SLOT);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BIT_W   = (DC_W > 1) ? $clog2(DC_W) : 1;

   localparam logic [CNT_W-1:0]  SET_END   = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  WIN_END   = CNT_W'(WIN - 1);
   localparam logic [CNT_W-1:0]  SLOT_END  = CNT_W'(SLOT - 1);
   localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(DC_W - 1);
   localparam logic [DC_W-1:0]   DC_MSB    = DC_W'(1 << (DC_W - 1));
   localparam logic [CHW-1:0]    LAST_CH   = CHW'(NCH - 1);
   localparam logic [ADC_W:0]    TGT_LO_V  = (ADC_W + 1)'(TGT_LO);
   localparam logic [ADC_W:0]    TGT_HI_V  = (ADC_W + 1)'(TGT_HI);
   localparam logic [ADC_W-1:0]  CLIP_LO_V = ADC_W'(CLIP_LO);
   localparam logic [ADC_W-1:0]  CLIP_HI_V = ADC_W'(CLIP_HI);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_MEASURE, S_DC_EVAL, S_GAIN_EVAL, S_NEXT_CH, S_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  phase_q, phase_d;
   logic [ADC_W-1:0]      min_q, min_d, max_q, max_d;
   logic [DC_W-1:0]       dc_comp_q, dc_comp_d;
   logic [GAIN_W-1:0]     pga_gain_q, pga_gain_d;
   logic [NCH-1:0]        led_en_q, led_en_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [NCH-1:0]        cal_err_q, cal_err_d;
   logic [NCH*DC_W-1:0]   dc_store_q, dc_store_d;
   logic [NCH*GAIN_W-1:0] gain_store_q, gain_store_d;
   logic [NCH*ADC_W-1:0]  ch_value_q, ch_value_d;
   logic                  value_valid_q, value_valid_d;
   logic [CHW-1:0]        value_ch_q, value_ch_d;
   logic                  clk_filter_q, clk_filter_d;

   logic [ADC_W:0]        sum_s, mid_s;
   logic                  in_band_s, clipped_s;
   logic [CHW-1:0]        ch_inc_s, nxt_ch_s;
   logic [DC_W-1:0]       code_s;

   function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] k);
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) begin
         v[i] = (k == CHW'(i));
      end
      return v;
   endfunction

   // Midpoint kept at ADC_W+1 bits so min+max never overflows.
   assign sum_s     = {1'b0, min_q} + {1'b0, max_q};
   assign mid_s     = sum_s >> 1;
   assign in_band_s = (mid_s >= TGT_LO_V) && (mid_s <= TGT_HI_V);
   assign clipped_s = (min_q < CLIP_LO_V) || (max_q > CLIP_HI_V);
   assign ch_inc_s  = ch_q + CHW'(1);
   assign nxt_ch_s  = (ch_q == LAST_CH) ? '0 : ch_inc_s;

   // State and datapath registers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         ch_q          <= '0;
         bit_q         <= '0;
         phase_q       <= 1'b0;
         min_q         <= '0;
         max_q         <= '0;
         dc_comp_q     <= '0;
         pga_gain_q    <= '0;
         led_en_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cal_err_q     <= '0;
         dc_store_q    <= '0;
         gain_store_q  <= '0;
         ch_value_q    <= '0;
         value_valid_q <= 1'b0;
         value_ch_q    <= '0;
         clk_filter_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ch_q          <= ch_d;
         bit_q         <= bit_d;
         phase_q       <= phase_d;
         min_q         <= min_d;
         max_q         <= max_d;
         dc_comp_q     <= dc_comp_d;
         pga_gain_q    <= pga_gain_d;
         led_en_q      <= led_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         cal_err_q     <= cal_err_d;
         dc_store_q    <= dc_store_d;
         gain_store_q  <= gain_store_d;
         ch_value_q    <= ch_value_d;
         value_valid_q <= value_valid_d;
         value_ch_q    <= value_ch_d;
         clk_filter_q  <= clk_filter_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (find_setting) begin
         state_d = S_SETTLE;
      end else begin
         case (state_q)
            S_IDLE:      state_d = S_IDLE;
            S_SETTLE:    state_d = (cnt_q == SET_END) ? S_MEASURE : S_SETTLE;
            S_MEASURE:   state_d = (cnt_q != WIN_END) ? S_MEASURE : (phase_q ? S_GAIN_EVAL : S_DC_EVAL);
            S_DC_EVAL:   state_d = S_SETTLE;
            S_GAIN_EVAL: state_d = (clipped_s || (pga_gain_q == '1)) ? S_NEXT_CH : S_SETTLE;
            S_NEXT_CH:   state_d = (ch_q == LAST_CH) ? S_RUN : S_SETTLE;
            S_RUN:       state_d = S_RUN;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Settings, search pointer, window statistics and RUN capture
   always_comb begin
      cnt_d         = cnt_q;
      ch_d          = ch_q;
      bit_d         = bit_q;
      phase_d       = phase_q;
      min_d         = min_q;
      max_d         = max_q;
      dc_comp_d     = dc_comp_q;
      pga_gain_d    = pga_gain_q;
      led_en_d      = led_en_q;
      busy_d        = busy_q;
      done_d        = done_q;
      cal_err_d     = cal_err_q;
      dc_store_d    = dc_store_q;
      gain_store_d  = gain_store_q;
      ch_value_d    = ch_value_q;
      value_valid_d = 1'b0;
      value_ch_d    = value_ch_q;
      clk_filter_d  = ~clk_filter_q;
      code_s        = dc_comp_q;
      if (find_setting) begin
         cnt_d      = '0;
         ch_d       = '0;
         bit_d      = BIT_TOP;
         phase_d    = 1'b0;
         dc_comp_d  = DC_MSB;
         pga_gain_d = '0;
         led_en_d   = onehot('0);
         busy_d     = 1'b1;
         done_d     = 1'b0;
         cal_err_d  = '0;
      end else begin
         case (state_q)
            S_SETTLE: begin
               if (cnt_q == SET_END) begin
                  cnt_d = '0;
                  min_d = '1;
                  max_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_MEASURE: begin
               min_d = (ADC < min_q) ? ADC : min_q;
               max_d = (ADC > max_q) ? ADC : max_q;
               cnt_d = (cnt_q == WIN_END) ? '0 : (cnt_q + CNT_W'(1));
            end
            S_DC_EVAL: begin
               cnt_d = '0;
               code_s[bit_q] = (mid_s > TGT_HI_V) ? 1'b0 : dc_comp_q[bit_q];
               if (in_band_s) begin
                  dc_store_d[ch_q*DC_W +: DC_W] = dc_comp_q;
                  phase_d    = 1'b1;
                  pga_gain_d = '0;
               end else if (bit_q == '0) begin
                  dc_store_d[ch_q*DC_W +: DC_W] = code_s;
                  cal_err_d[ch_q] = 1'b1;
                  dc_comp_d  = code_s;
                  phase_d    = 1'b1;
                  pga_gain_d = '0;
               end else begin
                  code_s[bit_q - BIT_W'(1)] = 1'b1;
                  dc_comp_d = code_s;
                  bit_d     = bit_q - BIT_W'(1);
               end
            end
            S_GAIN_EVAL: begin
               cnt_d = '0;
               if (clipped_s) begin
                  gain_store_d[ch_q*GAIN_W +: GAIN_W] = (pga_gain_q == '0) ? '0 : (pga_gain_q - GAIN_W'(1));
               end else if (pga_gain_q == '1) begin
                  gain_store_d[ch_q*GAIN_W +: GAIN_W] = '1;
               end else begin
                  pga_gain_d = pga_gain_q + GAIN_W'(1);
               end
            end
            S_NEXT_CH: begin
               cnt_d = '0;
               if (ch_q == LAST_CH) begin
                  ch_d       = '0;
                  led_en_d   = onehot('0);
                  dc_comp_d  = dc_store_q[DC_W-1:0];
                  pga_gain_d = gain_store_q[GAIN_W-1:0];
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  ch_d       = ch_inc_s;
                  led_en_d   = onehot(ch_inc_s);
                  dc_comp_d  = DC_MSB;
                  pga_gain_d = '0;
                  bit_d      = BIT_TOP;
                  phase_d    = 1'b0;
               end
            end
            S_RUN: begin
               // Capture and move to the next slot together so settings switch only on slot edges.
               if (cnt_q == SLOT_END) begin
                  cnt_d = '0;
                  ch_value_d[ch_q*ADC_W +: ADC_W] = ADC;
                  value_valid_d = 1'b1;
                  value_ch_d    = ch_q;
                  ch_d          = nxt_ch_s;
                  led_en_d      = onehot(nxt_ch_s);
                  dc_comp_d     = dc_store_q[nxt_ch_s*DC_W +: DC_W];
                  pga_gain_d    = gain_store_q[nxt_ch_s*GAIN_W +: GAIN_W];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   assign led_en      = led_en_q;
   assign dc_comp     = dc_comp_q;
   assign pga_gain    = pga_gain_q;
   assign clk_filter  = clk_filter_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cal_err     = cal_err_q;
   assign ch_value    = ch_value_q;
   assign value_valid = value_valid_q;
   assign value_ch    = value_ch_q;

endmodule

// File: tb/tb_afe_calib_ctrl.sv
// Directed bench for afe_calib_ctrl: DC search, gain ramp, unreachable band, RUN slots,
// restart and asynchronous reset, with an ADC stimulus model driven from the DUT settings.
module tb_afe_calib_ctrl;

   logic        CLK;
   logic        rst_n;
   logic [7:0]  ADC;
   logic        find_setting;
   logic [2:0]  led_en;
   logic [6:0]  dc_comp;
   logic [3:0]  pga_gain;
   logic        clk_filter;
   logic        busy;
   logic        done;
   logic [2:0]  cal_err;
   logic [23:0] ch_value;
   logic        value_valid;
   logic [1:0]  value_ch;

   afe_calib_ctrl #(
      .NCH(3), .ADC_W(8), .DC_W(7), .GAIN_W(4), .WIN(16), .SETTLE(4), .SLOT(10),
      .TGT_LO(120), .TGT_HI(135), .CLIP_LO(10), .CLIP_HI(245)
   ) dut (
      .CLK(CLK), .rst_n(rst_n), .ADC(ADC), .find_setting(find_setting),
      .led_en(led_en), .dc_comp(dc_comp), .pga_gain(pga_gain), .clk_filter(clk_filter),
      .busy(busy), .done(done), .cal_err(cal_err), .ch_value(ch_value),
      .value_valid(value_valid), .value_ch(value_ch)
   );

   typedef struct packed {
      logic [2:0] led;
      logic [6:0] dc;
      logic [3:0] gain;
   } rec_t;

   rec_t rec_q[$];
   int   checks_cnt = 0;
   int   errors_cnt = 0;
   int   mode = 0;      // 0: triangle around 2*dc+20, 1: constant 250, 2: ramp
   int   ph = 0;
   int   ramp = 100;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Drive ADC for the coming cycle from the current settings, then advance one clock.
   task automatic step();
      int v;
      int a;
      int off;
      case (mode)
         0: begin
            a = 1 << int'(pga_gain);
            case (ph % 8)
               0: off = -a;
               1: off = -a / 2;
               2: off = 0;
               3: off = a / 2;
               4: off = a;
               5: off = a / 2;
               6: off = 0;
               default: off = -a / 2;
            endcase
            v = 2 * int'(dc_comp) + 20 + off;
         end
         1: v = 250;
         default: begin
            ramp = (ramp + 3) % 256;
            v = ramp;
         end
      endcase
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      ADC = 8'(v);
      ph++;
      @(posedge CLK);
      #1;
      if (busy && (rec_q.size() == 0 || rec_q[$] != {led_en, dc_comp, pga_gain}))
         rec_q.push_back({led_en, dc_comp, pga_gain});
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000 && !done; i++) step();
      check_val(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic start_cal();
      rec_q.delete();
      find_setting = 1'b1;
      step();
      find_setting = 1'b0;
   endtask

   initial begin
      int exp_dc[8];
      int exp_ch;
      rst_n = 1'b0;
      find_setting = 1'b0;
      ADC = 8'd0;
      #12;
      check_val("rst_led", {29'd0, led_en}, 32'd0);
      check_val("rst_dc", {25'd0, dc_comp}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_clkf", {31'd0, clk_filter}, 32'd0);
      check_val("rst_val", {8'd0, ch_value}, 32'd0);
      rst_n = 1'b1;
      step();
      check_val("clkf_1", {31'd0, clk_filter}, 32'd1);
      step();
      check_val("clkf_2", {31'd0, clk_filter}, 32'd0);
      check_val("idle_led", {29'd0, led_en}, 32'd0);

      // Triangle model: DC search 64,32,48,56 then gain ramp to 7, stored gain 6
      mode = 0;
      rec_q.delete();
      find_setting = 1'b1;
      step();
      check_val("start_busy", {31'd0, busy}, 32'd1);
      check_val("start_led", {29'd0, led_en}, 32'd1);
      check_val("start_dc", {25'd0, dc_comp}, 32'd64);
      check_val("start_gain", {28'd0, pga_gain}, 32'd0);
      step();
      step();
      check_val("hold_dc", {25'd0, dc_comp}, 32'd64);
      check_val("hold_busy", {31'd0, busy}, 32'd1);
      find_setting = 1'b0;
      wait_done("tri_done");
      check_val("tri_nrec", rec_q.size(), 32'd33);
      if (rec_q.size() == 33) begin
         check_val("tri_dc0", {25'd0, rec_q[0].dc}, 32'd64);
         check_val("tri_dc1", {25'd0, rec_q[1].dc}, 32'd32);
         check_val("tri_dc2", {25'd0, rec_q[2].dc}, 32'd48);
         check_val("tri_dc3", {25'd0, rec_q[3].dc}, 32'd56);
         check_val("tri_g7", {18'd0, rec_q[10]}, {18'd0, 3'd1, 7'd56, 4'd7});
         check_val("tri_ch1", {18'd0, rec_q[11]}, {18'd0, 3'd2, 7'd64, 4'd0});
      end
      check_val("tri_err", {29'd0, cal_err}, 32'd0);
      check_val("tri_busy", {31'd0, busy}, 32'd0);
      check_val("run_dc0", {25'd0, dc_comp}, 32'd56);
      check_val("run_gain0", {28'd0, pga_gain}, 32'd6);
      check_val("run_led0", {29'd0, led_en}, 32'd1);

      // RUN slots: done rise is t=0, strobes every 10 cycles
      mode = 2;
      for (int t = 1; t <= 35; t++) begin
         step();
         check_val("run_led", {29'd0, led_en}, 32'd1 << ((t / 10) % 3));
         check_val("run_vv", {31'd0, value_valid}, (t % 10 == 0) ? 32'd1 : 32'd0);
         if (t % 10 == 0) begin
            exp_ch = ((t / 10) - 1) % 3;
            check_val("run_vch", {30'd0, value_ch}, exp_ch);
            check_val("run_val", {24'd0, ch_value[exp_ch*8 +: 8]}, {24'd0, ADC});
         end
         if (t == 15) check_val("run_gain1", {28'd0, pga_gain}, 32'd6);
      end

      // Restart from RUN with an unreachable band (ADC stuck at 250)
      mode = 1;
      start_cal();
      check_val("rs_busy", {31'd0, busy}, 32'd1);
      check_val("rs_done", {31'd0, done}, 32'd0);
      check_val("rs_dc", {25'd0, dc_comp}, 32'd64);
      check_val("rs_led", {29'd0, led_en}, 32'd1);
      check_val("rs_err", {29'd0, cal_err}, 32'd0);
      wait_done("ur_done");
      exp_dc = '{64, 32, 16, 8, 4, 2, 1, 0};
      check_val("ur_nrec", rec_q.size(), 32'd24);
      if (rec_q.size() == 24) begin
         for (int i = 0; i < 8; i++) begin
            check_val("ur_dc", {18'd0, rec_q[i]}, {18'd0, 3'd1, 7'(exp_dc[i]), 4'd0});
         end
         check_val("ur_ch1", {18'd0, rec_q[8]}, {18'd0, 3'd2, 7'd64, 4'd0});
      end
      check_val("ur_err", {29'd0, cal_err}, 32'd7);
      check_val("ur_dc_st", {25'd0, dc_comp}, 32'd0);
      check_val("ur_gain_st", {28'd0, pga_gain}, 32'd0);

      // Asynchronous reset in the middle of a measurement window
      mode = 0;
      start_cal();
      for (int i = 0; i < 8; i++) step();
      check_val("mr_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("ar_led", {29'd0, led_en}, 32'd0);
      check_val("ar_dc", {25'd0, dc_comp}, 32'd0);
      check_val("ar_gain", {28'd0, pga_gain}, 32'd0);
      check_val("ar_busy", {31'd0, busy}, 32'd0);
      check_val("ar_done", {31'd0, done}, 32'd0);
      check_val("ar_val", {8'd0, ch_value}, 32'd0);
      check_val("ar_clkf", {31'd0, clk_filter}, 32'd0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) step();
      check_val("post_busy", {31'd0, busy}, 32'd0);
      check_val("post_led", {29'd0, led_en}, 32'd0);
      check_val("post_dc", {25'd0, dc_comp}, 32'd0);
      check_val("post_vv", {31'd0, value_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
